// File: rtl/seg7_scan_ctrl_if.sv
// ============================================================================
//  Module      : seg7_scan_ctrl_if
//  Description : Frame-load, decoder and display-pin signals of the
//                seg7_scan_ctrl 7-segment scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg7_scan_ctrl_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] data_in;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                pending;
    logic                frame_tick;
    logic [3:0]          hex;
    logic [7:0]          seg_in;
    logic [7:0]          seg_out;
    logic [DIGITS-1:0]   an;

    modport master (
        output data_in, dp_in, load, seg_in,
        input  pending, frame_tick, hex, seg_out, an
    );

    modport slave (
        input  data_in, dp_in, load, seg_in,
        output pending, frame_tick, hex, seg_out, an
    );
endinterface

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
//  Module      : seg7_scan_ctrl
//  Description : Time-multiplexed, tear-free scan controller for a
//                common-anode multi-digit 7-segment display.
//                Optional macro SEG7_LZ_BLANK_EN enables leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    seg7_scan_ctrl_if.slave  bus
);
    localparam int PW = $clog2(PRESCALE);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NW = 4 * DIGITS;

    localparam logic [PW-1:0] c_PCNT_MAX  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] c_BLANK_END = PW'(BLANK_CYCLES);
    localparam logic [DW-1:0] c_DIG_MAX   = DW'(DIGITS - 1);

    localparam logic [0:0] c_SLOT_BLANK = 1'b0;
    localparam logic [0:0] c_SLOT_LIT   = 1'b1;

    logic [PW-1:0]     r_pcnt;
    logic [DW-1:0]     r_dig;
    logic [NW-1:0]     r_stg_data;
    logic [DIGITS-1:0] r_stg_dp;
    logic [NW-1:0]     r_shd_data;
    logic [DIGITS-1:0] r_shd_dp;
    logic              r_pending;
    logic              r_frame_tick;
    logic [3:0]        r_hex;
    logic [0:0]        r_slot;
    logic [DIGITS-1:0] r_an;

    logic              w_pwrap;
    logic              w_boundary;
    logic [PW-1:0]     w_pcnt_nxt;
    logic [DW-1:0]     w_dig_nxt;
    logic [NW-1:0]     w_shd_data_nxt;
    logic [DIGITS-1:0] w_shd_dp_nxt;
    logic              w_lz_blank;
    logic [0:0]        w_slot_nxt;
    logic [DIGITS-1:0] w_an_nxt;
    logic [3:0]        w_hex_nxt;
    logic              w_unused_dec_dp;

    assign w_pwrap    = (r_pcnt == c_PCNT_MAX);
    assign w_boundary = w_pwrap && (r_dig == c_DIG_MAX);

    assign w_pcnt_nxt = w_pwrap ? '0 : r_pcnt + PW'(1);
    assign w_dig_nxt  = !w_pwrap ? r_dig :
                        (r_dig == c_DIG_MAX) ? '0 : r_dig + DW'(1);

    // A load landing on the boundary bypasses staging so it is not a frame late.
    assign w_shd_data_nxt = !w_boundary ? r_shd_data :
                            bus.load ? bus.data_in : r_stg_data;
    assign w_shd_dp_nxt   = !w_boundary ? r_shd_dp :
                            bus.load ? bus.dp_in : r_stg_dp;

`ifdef SEG7_LZ_BLANK_EN
    assign w_lz_blank = (w_dig_nxt != '0) && !w_shd_dp_nxt[w_dig_nxt] &&
                        ((w_shd_data_nxt >> {w_dig_nxt, 2'b00}) == '0);
`else
    assign w_lz_blank = 1'b0;
`endif

    // Slot state, anode and decoder nibble are computed from next-state values
    // so they change on the same edge as the counters they follow.
    assign w_slot_nxt = ((w_pcnt_nxt < c_BLANK_END) || w_lz_blank) ? c_SLOT_BLANK
                                                                     : c_SLOT_LIT;
    assign w_an_nxt   = (w_slot_nxt == c_SLOT_LIT) ? ~(DIGITS'(1) << w_dig_nxt) : '1;
    assign w_hex_nxt  = w_shd_data_nxt[{w_dig_nxt, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt       <= '0;
            r_dig        <= '0;
            r_stg_data   <= '0;
            r_stg_dp     <= '0;
            r_shd_data   <= '0;
            r_shd_dp     <= '0;
            r_pending    <= 1'b0;
            r_frame_tick <= 1'b0;
            r_hex        <= 4'h0;
            r_slot       <= c_SLOT_BLANK;
            r_an         <= '1;
        end else begin
            r_pcnt       <= w_pcnt_nxt;
            r_dig        <= w_dig_nxt;
            r_shd_data   <= w_shd_data_nxt;
            r_shd_dp     <= w_shd_dp_nxt;
            r_frame_tick <= w_boundary;
            r_hex        <= w_hex_nxt;
            r_slot       <= w_slot_nxt;
            r_an         <= w_an_nxt;
            if (bus.load) begin
                r_stg_data <= bus.data_in;
                r_stg_dp   <= bus.dp_in;
            end
            if (w_boundary) begin
                r_pending <= 1'b0;
            end else if (bus.load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // The decoder's own dp bit is replaced by the per-digit request.
    assign w_unused_dec_dp = bus.seg_in[0];

    assign bus.seg_out    = (r_slot == c_SLOT_LIT) ? {bus.seg_in[7:1], ~r_shd_dp[r_dig]}
                                                   : 8'hFF;
    assign bus.an         = r_an;
    assign bus.hex        = r_hex;
    assign bus.pending    = r_pending;
    assign bus.frame_tick = r_frame_tick;

endmodule

`default_nettype wire
